// File: rtl/led_display_queue_pkg.sv
// Shared definitions for the mini ALU slice: opcodes plus the LED display
// queue state encodings and default hold time.
package led_display_queue_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_LED = 4'hF;

  localparam logic [0:0] LDQ_IDLE = 1'b0;
  localparam logic [0:0] LDQ_HOLD = 1'b1;

  localparam int LDQ_DEFAULT_HOLD_CYCLES = 25000000;
  localparam int LDQ_DATA_WIDTH          = 8;

endpackage

// File: rtl/led_display_queue_fifo_sync.sv
// Small synchronous circular FIFO. The caller decides when a push or pop is
// legal; this block trusts iPush/iPop and only keeps storage, pointers and count.
import led_display_queue_pkg::*;

module fifo_sync #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = LDQ_DATA_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPush,
  input  logic                  iPop,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic [DATA_WIDTH-1:0] oData,
  output logic [ADDR_WIDTH:0]   oCount
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH:0]   count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (iPush) wrPtr <= wrPtr + 1'b1;
      if (iPop)  rdPtr <= rdPtr + 1'b1;
      case ({iPush, iPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge Clock) begin
    if (!Reset && iPush) mem[wrPtr] <= iData;
  end

  assign oData  = mem[rdPtr];
  assign oCount = count;

endmodule

// File: rtl/led_display_queue.sv
// Buffers ALU LED writes and shows each one on the board LEDs for HOLD_CYCLES
// cycles, so bursts of LED instructions stay visible to a human.
import led_display_queue_pkg::*;

module led_display_queue #(
  parameter int DEPTH         = 4,
  parameter int ADDR_WIDTH    = 2,
  parameter int HOLD_CYCLES   = LDQ_DEFAULT_HOLD_CYCLES,
  parameter int COUNTER_WIDTH = 25
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWriteEnable,
  input  logic [7:0] iData,
  output logic [7:0] oLed,
  output logic       oEmpty,
  output logic       oFull,
  output logic       oBusy,
  output logic       oOverflow
);

  localparam logic [ADDR_WIDTH:0]    FULL_COUNT  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [COUNTER_WIDTH-1:0] HOLD_RELOAD = COUNTER_WIDTH'(HOLD_CYCLES - 1);

  logic [0:0]               state;
  logic [COUNTER_WIDTH-1:0] holdCount;
  logic [ADDR_WIDTH:0]      count;
  logic [7:0]               headData;
  logic                     holdDone;
  logic                     pop;
  logic                     pushAccept;

  // Write interface: iWriteEnable is a one-cycle strobe with no ready/backpressure.
  // A strobe is taken when there is room, or when the head leaves at the same
  // edge; otherwise the byte is dropped and oOverflow latches until Reset.
  always_comb begin
    holdDone   = (state == LDQ_IDLE) || (holdCount == '0);
    pop        = holdDone && (count != '0);
    pushAccept = iWriteEnable && ((count != FULL_COUNT) || pop);
  end

  fifo_sync #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (8)
  ) u_fifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .iPush  (pushAccept),
    .iPop   (pop),
    .iData  (iData),
    .oData  (headData),
    .oCount (count)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= LDQ_IDLE;
      holdCount <= '0;
      oLed      <= 8'h00;
      oOverflow <= 1'b0;
    end else begin
      if (iWriteEnable && !pushAccept) oOverflow <= 1'b1;
      if (pop) begin
        oLed      <= headData;
        holdCount <= HOLD_RELOAD;
        state     <= LDQ_HOLD;
      end else if (state == LDQ_HOLD) begin
        if (holdCount != '0) holdCount <= holdCount - 1'b1;
        else                 state     <= LDQ_IDLE;
      end
    end
  end

  assign oEmpty = (count == '0);
  assign oFull  = (count == FULL_COUNT);
  assign oBusy  = (state == LDQ_HOLD);

endmodule

// File: tb/tb_led_display_queue.sv
// Bench for led_display_queue: two instances (hold 4 and hold 1) share stimulus
// and are compared every cycle against a time-based queue model.
module tb_led_display_queue;

  localparam int DEPTH = 4;

  logic       Clock;
  logic       Reset;
  logic       iWriteEnable;
  logic [7:0] iData;

  logic [7:0] ledA, ledB;
  logic       emptyA, emptyB, fullA, fullB, busyA, busyB, ovfA, ovfB;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model: pending list (head at index 0), shown value, sticky flag, last pop time
  int         holdOf [2] = '{4, 1};
  logic [7:0] mList [2][DEPTH];
  int         mSize [2];
  logic [7:0] mLed [2];
  logic       mOvf [2];
  logic       mBusy [2];
  int         mLastPop [2];

  led_display_queue #(.DEPTH(4), .ADDR_WIDTH(2), .HOLD_CYCLES(4), .COUNTER_WIDTH(25)) dutA (
    .Clock(Clock), .Reset(Reset), .iWriteEnable(iWriteEnable), .iData(iData),
    .oLed(ledA), .oEmpty(emptyA), .oFull(fullA), .oBusy(busyA), .oOverflow(ovfA)
  );

  led_display_queue #(.DEPTH(4), .ADDR_WIDTH(2), .HOLD_CYCLES(1), .COUNTER_WIDTH(25)) dutB (
    .Clock(Clock), .Reset(Reset), .iWriteEnable(iWriteEnable), .iData(iData),
    .oLed(ledB), .oEmpty(emptyB), .oFull(fullB), .oBusy(busyB), .oOverflow(ovfB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0h required=%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic modelStep(input int k, input logic rst, input logic we, input logic [7:0] d);
    bit popNow;
    if (rst) begin
      mSize[k] = 0; mLed[k] = 8'h00; mOvf[k] = 1'b0; mBusy[k] = 1'b0; mLastPop[k] = -100;
      return;
    end
    popNow = (mSize[k] > 0) && (cyc >= mLastPop[k] + holdOf[k]);
    if (popNow) begin
      mLed[k] = mList[k][0];
      for (int i = 0; i < DEPTH - 1; i++) mList[k][i] = mList[k][i+1];
      mSize[k]--;
      mLastPop[k] = cyc;
    end
    if (we) begin
      if (mSize[k] < DEPTH) begin
        mList[k][mSize[k]] = d;
        mSize[k]++;
      end else begin
        mOvf[k] = 1'b1;
      end
    end
    mBusy[k] = (cyc < mLastPop[k] + holdOf[k]);
  endtask

  task automatic checkAll();
    checkVal("A.led",   ledA,   mLed[0]);
    checkVal("A.empty", {7'd0, emptyA}, {7'd0, mSize[0] == 0});
    checkVal("A.full",  {7'd0, fullA},  {7'd0, mSize[0] == DEPTH});
    checkVal("A.busy",  {7'd0, busyA},  {7'd0, mBusy[0]});
    checkVal("A.ovf",   {7'd0, ovfA},   {7'd0, mOvf[0]});
    checkVal("B.led",   ledB,   mLed[1]);
    checkVal("B.empty", {7'd0, emptyB}, {7'd0, mSize[1] == 0});
    checkVal("B.full",  {7'd0, fullB},  {7'd0, mSize[1] == DEPTH});
    checkVal("B.busy",  {7'd0, busyB},  {7'd0, mBusy[1]});
    checkVal("B.ovf",   {7'd0, ovfB},   {7'd0, mOvf[1]});
  endtask

  // one clock: drive, take the edge, advance the model, sample 1 unit later
  task automatic doCycle(input logic rst, input logic we, input logic [7:0] d);
    Reset = rst; iWriteEnable = we; iData = d;
    @(posedge Clock);
    modelStep(0, rst, we, d);
    modelStep(1, rst, we, d);
    cyc++;
    #1;
    checkAll();
  endtask

  task automatic doReset();
    doCycle(1'b1, 1'b0, 8'h00);
    doCycle(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    Reset = 1'b1; iWriteEnable = 1'b0; iData = 8'h00;
    doReset();

    // reset after random writes
    for (int i = 0; i < 6; i++) doCycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    doReset();
    checkVal("t1.led",   ledA, 8'h00);
    checkVal("t1.empty", {7'd0, emptyA}, 8'd1);
    checkVal("t1.full",  {7'd0, fullA},  8'd0);
    checkVal("t1.busy",  {7'd0, busyA},  8'd0);
    checkVal("t1.ovf",   {7'd0, ovfA},   8'd0);

    // single push, held for 4 cycles then idle
    doCycle(1'b0, 1'b1, 8'hA5);
    for (int e = 1; e <= 4; e++) begin
      doCycle(1'b0, 1'b0, 8'h00);
      checkVal("t2.led",  ledA, 8'hA5);
      checkVal("t2.busy", {7'd0, busyA}, 8'd1);
    end
    doCycle(1'b0, 1'b0, 8'h00);
    checkVal("t2.idle", {7'd0, busyA}, 8'd0);
    doCycle(1'b0, 1'b0, 8'h00);
    checkVal("t2.keep", ledA, 8'hA5);

    // burst of seven, last one dropped
    doReset();
    for (int i = 1; i <= 7; i++) doCycle(1'b0, 1'b1, 8'(i));
    checkVal("t3.ovf", {7'd0, ovfA}, 8'd1);
    checkVal("t3.led6", ledA, 8'h02);
    for (int e = 7; e <= 27; e++) begin
      int shown;
      doCycle(1'b0, 1'b0, 8'h00);
      shown = 1 + (e - 1) / 4;
      if (shown > 6) shown = 6;
      checkVal("t3.seq", ledA, 8'(shown));
    end

    // reset mid-hold discards queued entries
    doReset();
    doCycle(1'b0, 1'b1, 8'h3C);
    doCycle(1'b0, 1'b1, 8'h11);
    doCycle(1'b0, 1'b1, 8'h22);
    checkVal("t4.pre", ledA, 8'h3C);
    doCycle(1'b1, 1'b0, 8'h00);
    checkVal("t4.led",   ledA, 8'h00);
    checkVal("t4.empty", {7'd0, emptyA}, 8'd1);
    checkVal("t4.busy",  {7'd0, busyA},  8'd0);
    for (int i = 0; i < 8; i++) begin
      doCycle(1'b0, 1'b0, 8'h00);
      checkVal("t4.gone", ledA, 8'h00);
    end

    // hold of one cycle: one pop per edge
    doReset();
    doCycle(1'b0, 1'b1, 8'h10);
    doCycle(1'b0, 1'b1, 8'h20);
    checkVal("t5.e1", ledB, 8'h10);
    doCycle(1'b0, 1'b1, 8'h30);
    checkVal("t5.e2", ledB, 8'h20);
    checkVal("t5.full", {7'd0, fullB}, 8'd0);
    doCycle(1'b0, 1'b0, 8'h00);
    checkVal("t5.e3", ledB, 8'h30);

    // saturate while holding; only the push on the pop edge gets in
    doReset();
    for (int i = 0; i < 5; i++) doCycle(1'b0, 1'b1, 8'(8'h40 + i));
    checkVal("t6.full", {7'd0, fullA}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      doCycle(1'b0, 1'b1, 8'hFF);
      checkVal("t6.fullk", {7'd0, fullA}, 8'd1);
    end
    checkVal("t6.ovf", {7'd0, ovfA}, 8'd1);
    for (int i = 0; i < 30; i++) doCycle(1'b0, 1'b0, 8'h00);
    checkVal("t6.sticky", {7'd0, ovfA}, 8'd1);
    doReset();
    checkVal("t6.clr", {7'd0, ovfA}, 8'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      doCycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) != 0), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
